// File: rtl/rv32_ctrl_pkg.sv
// rtl/rv32_ctrl_pkg.sv - shared state type and parameter defaults for the PC redirect controller
package rv32_ctrl_pkg;

  localparam int XLEN_DEFAULT         = 32;
  localparam int FLUSH_CYCLES_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } redirect_state_e;

endpackage

// File: rtl/branch_target_gen.sv
// rtl/branch_target_gen.sv - combinational control-flow target adder with JALR masking and alignment check
module branch_target_gen #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            is_jalr,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] sum;

  always_comb begin
    base       = is_jalr ? rs1_data : pc;
    sum        = base + imm;
    target     = is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;
    // Only bit 1 matters: bit 0 is always clear for valid branch/JAL immediates and masked for JALR.
    misaligned = target[1];
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - EX-stage redirect handshake and flush sequencer; PC_REDIRECT_STATS_EN adds counters
module pc_redirect_ctrl
  import rv32_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT,
  parameter int XLEN         = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jal,
  input  logic            ex_is_jalr,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1_data,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            ex_stall,
  output logic            misalign_exc,
  output logic [XLEN-1:0] misalign_addr
`ifdef PC_REDIRECT_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_redirects
`endif
);

  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

  redirect_state_e state;
  logic [2:0]      flush_cnt;
  logic [XLEN-1:0] target;
  logic            target_misaligned;
  logic            cf_valid;
  logic            request;

  branch_target_gen #(.XLEN(XLEN)) u_target (
    .pc         (ex_pc),
    .imm        (ex_imm),
    .rs1_data   (ex_rs1_data),
    .is_jalr    (ex_is_jalr),
    .target     (target),
    .misaligned (target_misaligned)
  );

  // Anything EX presents outside IDLE is wrong-path and never counted or acted on.
  assign cf_valid = (state == ST_IDLE) && ex_valid && (ex_is_branch || ex_is_jal || ex_is_jalr);
  assign request  = (state == ST_IDLE) && ex_valid &&
                    (ex_is_jal || ex_is_jalr || (ex_is_branch && branch_taken));

  assign redirect_valid = (state == ST_REDIRECT);
  assign ex_stall       = (state == ST_REDIRECT);
  assign flush_ifid     = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      flush_cnt     <= 3'd0;
      redirect_pc   <= '0;
      flush_idex    <= 1'b0;
      misalign_exc  <= 1'b0;
      misalign_addr <= '0;
    end else begin
      flush_idex   <= 1'b0;
      misalign_exc <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (request) begin
            flush_idex <= 1'b1;
            if (target_misaligned) begin
              misalign_exc  <= 1'b1;
              misalign_addr <= target;
            end else begin
              state       <= ST_REDIRECT;
              redirect_pc <= target;
            end
          end
        end
        ST_REDIRECT: begin
          if (redirect_ready) begin
            state     <= ST_FLUSH;
            flush_cnt <= CNT_LOAD;
          end
        end
        ST_FLUSH: begin
          if (flush_cnt == 3'd0) begin
            state <= ST_IDLE;
          end else begin
            flush_cnt <= flush_cnt - 3'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef PC_REDIRECT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches  <= 32'd0;
      stat_redirects <= 32'd0;
    end else begin
      if (cf_valid && (stat_branches != 32'hFFFF_FFFF)) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if ((state == ST_REDIRECT) && redirect_ready && (stat_redirects != 32'hFFFF_FFFF)) begin
        stat_redirects <= stat_redirects + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - table-driven and directed-sequence bench for pc_redirect_ctrl
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr, branch_taken;
  logic [31:0] ex_pc, ex_imm, ex_rs1_data;
  logic        redirect_valid, redirect_ready;
  logic [31:0] redirect_pc;
  logic        flush_ifid, flush_idex, ex_stall, misalign_exc;
  logic [31:0] misalign_addr;
`ifdef PC_REDIRECT_STATS_EN
  logic [31:0] stat_branches, stat_redirects;
`endif

  int n_total = 0;
  int n_pass  = 0;

  pc_redirect_ctrl #(.FLUSH_CYCLES(2), .XLEN(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_is_branch   (ex_is_branch),
    .ex_is_jal      (ex_is_jal),
    .ex_is_jalr     (ex_is_jalr),
    .branch_taken   (branch_taken),
    .ex_pc          (ex_pc),
    .ex_imm         (ex_imm),
    .ex_rs1_data    (ex_rs1_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_ready (redirect_ready),
    .flush_ifid     (flush_ifid),
    .flush_idex     (flush_idex),
    .ex_stall       (ex_stall),
    .misalign_exc   (misalign_exc),
    .misalign_addr  (misalign_addr)
`ifdef PC_REDIRECT_STATS_EN
    ,
    .stat_branches  (stat_branches),
    .stat_redirects (stat_redirects)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v, br, jal, jalr, tk;
    logic [31:0] pc, imm, rs1;
    logic        e_rv;
    logic [31:0] e_rpc;
    logic        e_mexc;
    logic [31:0] e_maddr;
    logic        e_fidex, e_fifid, e_stall;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic br, input logic jal, input logic jalr,
                        input logic tk, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] rs1);
    ex_valid = v; ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
    branch_taken = tk; ex_pc = pc; ex_imm = imm; ex_rs1_data = rs1;
  endtask

  // Counts flush_ifid-high cycles from the current one until the controller is idle again.
  task automatic drain(output int nflush);
    nflush = 0;
    ex_valid = 1'b0;
    redirect_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!flush_ifid && !redirect_valid) break;
      nflush++;
      step();
    end
    chk("drain_idle", {30'd0, flush_ifid, redirect_valid}, 32'd0);
  endtask

  function automatic vec_t mk(input logic v, input logic br, input logic jal, input logic jalr,
                              input logic tk, input logic [31:0] pc, input logic [31:0] imm,
                              input logic [31:0] rs1, input logic e_rv, input logic [31:0] e_rpc,
                              input logic e_mexc, input logic [31:0] e_maddr);
    vec_t r;
    r.v = v; r.br = br; r.jal = jal; r.jalr = jalr; r.tk = tk;
    r.pc = pc; r.imm = imm; r.rs1 = rs1;
    r.e_rv = e_rv; r.e_rpc = e_rpc; r.e_mexc = e_mexc; r.e_maddr = e_maddr;
    r.e_fidex = e_rv | e_mexc;
    r.e_fifid = e_rv;
    r.e_stall = e_rv;
    return r;
  endfunction

  initial begin
    int nf;
    //           v  br jal jalr tk pc            imm           rs1           rv rpc           mexc maddr
    vecs[0] = mk(1, 1, 0, 0, 1, 32'h0000_0100, 32'h0000_0040, 32'h0,        1, 32'h0000_0140, 0, 32'h0);
    vecs[1] = mk(1, 1, 0, 0, 0, 32'h0000_0100, 32'h0000_0040, 32'h0,        0, 32'h0,        0, 32'h0);
    vecs[2] = mk(0, 0, 1, 0, 0, 32'h0000_0100, 32'h0000_0040, 32'h0,        0, 32'h0,        0, 32'h0);
    vecs[3] = mk(1, 0, 1, 0, 0, 32'h0000_1000, 32'hFFFF_FFF0, 32'h0,        1, 32'h0000_0FF0, 0, 32'h0);
    vecs[4] = mk(1, 0, 0, 1, 0, 32'h0000_0500, 32'h0000_0004, 32'h0000_2001, 1, 32'h0000_2004, 0, 32'h0);
    vecs[5] = mk(1, 0, 1, 0, 0, 32'h0000_0200, 32'h0000_0006, 32'h0,        0, 32'h0,        1, 32'h0000_0206);
    vecs[6] = mk(1, 1, 0, 0, 1, 32'hFFFF_FFF0, 32'h0000_0020, 32'h0,        1, 32'h0000_0010, 0, 32'h0);
    vecs[7] = mk(1, 0, 0, 1, 0, 32'h0000_0800, 32'h0000_0000, 32'h0000_0103, 0, 32'h0,        1, 32'h0000_0102);
    vecs[8] = mk(1, 0, 0, 1, 0, 32'h0000_0800, 32'h0000_0001, 32'h7FFF_FFFF, 1, 32'h8000_0000, 0, 32'h0);
    vecs[9] = mk(1, 0, 0, 0, 1, 32'h0000_0300, 32'h0000_0010, 32'h0,        0, 32'h0,        0, 32'h0);

    rst_n = 1'b0;
    redirect_ready = 1'b0;
    set_ex(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    #2;
    chk("reset_outputs", {27'd0, redirect_valid, flush_ifid, flush_idex, ex_stall, misalign_exc}, 32'd0);
    chk("reset_redirect_pc", redirect_pc, 32'd0);
    chk("reset_misalign_addr", misalign_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      set_ex(vecs[i].v, vecs[i].br, vecs[i].jal, vecs[i].jalr, vecs[i].tk,
             vecs[i].pc, vecs[i].imm, vecs[i].rs1);
      redirect_ready = 1'b0;
      step();
      chk($sformatf("v%0d_redirect_valid", i), {31'd0, redirect_valid}, {31'd0, vecs[i].e_rv});
      chk($sformatf("v%0d_misalign_exc", i), {31'd0, misalign_exc}, {31'd0, vecs[i].e_mexc});
      chk($sformatf("v%0d_flush_idex", i), {31'd0, flush_idex}, {31'd0, vecs[i].e_fidex});
      chk($sformatf("v%0d_flush_ifid", i), {31'd0, flush_ifid}, {31'd0, vecs[i].e_fifid});
      chk($sformatf("v%0d_ex_stall", i), {31'd0, ex_stall}, {31'd0, vecs[i].e_stall});
      if (vecs[i].e_rv) chk($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].e_rpc);
      if (vecs[i].e_mexc) chk($sformatf("v%0d_misalign_addr", i), misalign_addr, vecs[i].e_maddr);
      drain(nf);
    end

    // Taken BEQ with fetch ready: one REDIRECT cycle plus two FLUSH cycles.
    set_ex(1, 1, 0, 0, 1, 32'h100, 32'h40, 32'h0);
    redirect_ready = 1'b1;
    step();
    chk("beq_redirect_valid", {31'd0, redirect_valid}, 32'd1);
    chk("beq_redirect_pc", redirect_pc, 32'h140);
    drain(nf);
    chk("beq_flush_ifid_cycles", nf, 32'd3);

    // JALR held off by fetch for three cycles; target must stay stable under wrong-path EX noise.
    set_ex(1, 0, 0, 1, 0, 32'h0, 32'h4, 32'h2001);
    redirect_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("jalr_hold%0d_valid", c), {31'd0, redirect_valid}, 32'd1);
      chk($sformatf("jalr_hold%0d_pc", c), redirect_pc, 32'h2004);
      chk($sformatf("jalr_hold%0d_stall", c), {31'd0, ex_stall}, 32'd1);
      chk($sformatf("jalr_hold%0d_flush_idex", c), {31'd0, flush_idex}, (c == 0) ? 32'd1 : 32'd0);
      set_ex(1, 0, 1, 0, 0, 32'h4000 + 32'(c), 32'h8, 32'h0);
    end
    redirect_ready = 1'b1;
    ex_valid = 1'b0;
    step();
    chk("jalr_hs_valid", {31'd0, redirect_valid}, 32'd0);
    chk("jalr_hs_stall", {31'd0, ex_stall}, 32'd0);
    chk("jalr_hs_flush_ifid", {31'd0, flush_ifid}, 32'd1);
    drain(nf);
    chk("jalr_flush_cycles", nf, 32'd2);

    // Misaligned JAL target: single-cycle exception pulse, no redirect.
    set_ex(1, 0, 1, 0, 0, 32'h200, 32'h6, 32'h0);
    step();
    chk("mis_exc", {31'd0, misalign_exc}, 32'd1);
    chk("mis_addr", misalign_addr, 32'h206);
    chk("mis_no_redirect", {31'd0, redirect_valid}, 32'd0);
    ex_valid = 1'b0;
    step();
    chk("mis_exc_pulse_end", {31'd0, misalign_exc}, 32'd0);
    chk("mis_flush_idex_end", {31'd0, flush_idex}, 32'd0);
    chk("mis_addr_hold", misalign_addr, 32'h206);

    // Not-taken BNE, then a taken branch presented only during FLUSH.
    set_ex(1, 1, 0, 0, 0, 32'h600, 32'h20, 32'h0);
    step();
    chk("bne_nt_quiet", {27'd0, redirect_valid, flush_ifid, flush_idex, ex_stall, misalign_exc}, 32'd0);
    set_ex(1, 1, 0, 0, 1, 32'h700, 32'h10, 32'h0);
    redirect_ready = 1'b1;
    step();
    ex_valid = 1'b0;
    step();
    chk("fl_in_flush", {31'd0, flush_ifid}, 32'd1);
    set_ex(1, 1, 0, 0, 1, 32'h900, 32'h80, 32'h0);
    for (int c = 0; c < 2; c++) begin
      step();
      chk($sformatf("fl_wrongpath%0d", c), {30'd0, redirect_valid, flush_idex}, 32'd0);
    end
    ex_valid = 1'b0;
    chk("fl_idle_again", {31'd0, flush_ifid}, 32'd0);
    set_ex(1, 0, 1, 0, 0, 32'hA00, 32'h20, 32'h0);
    step();
    chk("fl_resume_pc", redirect_pc, 32'hA20);
    drain(nf);

    // Reset during REDIRECT clears everything asynchronously; first request after release is honored.
    set_ex(1, 0, 1, 0, 0, 32'hB00, 32'h40, 32'h0);
    redirect_ready = 1'b0;
    step();
    chk("rst_pre_valid", {31'd0, redirect_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {27'd0, redirect_valid, flush_ifid, flush_idex, ex_stall, misalign_exc}, 32'd0);
    chk("rst_mid_pc", redirect_pc, 32'd0);
    chk("rst_mid_maddr", misalign_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_ex(1, 0, 1, 0, 0, 32'h0, 32'h10, 32'h0);
    step();
    chk("rst_after_valid", {31'd0, redirect_valid}, 32'd1);
    chk("rst_after_pc", redirect_pc, 32'h10);
    drain(nf);

`ifdef PC_REDIRECT_STATS_EN
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("stat_reset_br", stat_branches, 32'd0);
    chk("stat_reset_rd", stat_redirects, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_ex(1, 1, 0, 0, (k < 5), 32'h1000 + 32'(k * 16), 32'h100, 32'h0);
      redirect_ready = 1'b1;
      step();
      drain(nf);
    end
    chk("stat_branches", stat_branches, 32'd8);
    chk("stat_redirects", stat_redirects, 32'd5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2: cycles flush_ifid stays asserted after the redirect handshake completes; legal range 1..7.
REQ-002 SHALL have parameter XLEN, default 32: datapath width.
REQ-003 SHALL have the single clock and reset: clk, input, 1, rising-edge clock; rst_n, input, 1, asynchronous active-low reset.
REQ-004 ex_valid, input, 1: EX stage holds a valid instruction.
REQ-005 ex_is_branch, ex_is_jal, ex_is_jalr, each input, 1: decoded class of the EX instruction; at most one is high.
REQ-006 branch_taken, input, 1: comparator outcome for the EX conditional branch.
REQ-007 ex_pc, ex_imm, ex_rs1_data, each input, XLEN: instruction PC, sign-extended immediate, forwarded rs1.
REQ-008 redirect_valid, output, 1; redirect_pc, output, XLEN; redirect_ready, input, 1: redirect handshake to fetch.
REQ-009 flush_ifid, flush_idex, each output, 1: squash the corresponding pipeline registers.
REQ-010 ex_stall, output, 1: freeze the EX stage.
REQ-011 misalign_exc, output, 1; misalign_addr, output, XLEN: misaligned-target exception pulse and faulting address.

Function
REQ-012 A redirect is requested when state is IDLE and ex_valid and (ex_is_jal or ex_is_jalr or (ex_is_branch and branch_taken)).
REQ-013 Target is ex_pc+ex_imm for branch/JAL, and (ex_rs1_data+ex_imm) with bit 0 cleared for JALR; sums wrap modulo 2^XLEN.
REQ-014 If target bit 1 is set, no redirect occurs; misalign_exc pulses high for exactly one cycle on the next edge, misalign_addr holds the target, and flush_idex pulses with it.
REQ-015 States: IDLE, REDIRECT, FLUSH.
REQ-016 IDLE -> REDIRECT on an aligned request: on the next edge redirect_valid=1, redirect_pc=target, flush_ifid=1, flush_idex=1.
REQ-017 In REDIRECT, redirect_valid and redirect_pc SHALL hold stable until redirect_ready is sampled high; ex_stall=1 and flush_ifid=1 throughout.
REQ-018 REDIRECT -> FLUSH on the edge where redirect_valid and redirect_ready are both high; the counter loads FLUSH_CYCLES-1.
REQ-019 In FLUSH, flush_ifid=1, redirect_valid=0 and ex_stall=0; the counter decrements each cycle; FLUSH -> IDLE when it reaches 0.
REQ-020 flush_idex SHALL be high only in the first cycle after a request, whether redirect or misalignment.
REQ-021 ex_valid is ignored outside IDLE; those instructions are wrong-path.
REQ-022 A not-taken conditional branch, or ex_valid=0, produces no output change.
REQ-023 Redirect latency from request cycle to redirect_valid is exactly 1 cycle; total flush_ifid assertion is (cycles in REDIRECT)+FLUSH_CYCLES.

Reset
REQ-024 rst_n low SHALL asynchronously force state IDLE, the counter to 0, and all outputs to 0, including redirect_pc and misalign_addr.
REQ-025 Reset asserted mid-REDIRECT drops redirect_valid immediately; no handshake completes.
REQ-026 After rst_n deasserts, the first request is honored on the first rising edge.

Configuration
REQ-027 Macro PC_REDIRECT_STATS_EN: when defined, outputs stat_branches and stat_redirects (32-bit each, saturating at 0xFFFFFFFF, reset to 0) count resolved control-flow instructions and completed redirects respectively.
REQ-028 Without PC_REDIRECT_STATS_EN, those ports and their counters SHALL be absent, with no other behavioural change.

Structure
REQ-029 Package rv32_ctrl_pkg SHALL hold the state enum type, the XLEN default, and the FLUSH_CYCLES default.
REQ-030 Target computation SHALL be one sub-module, branch_target_gen: combinational adder, JALR masking, and misalignment check.

Verification
REQ-031 Taken BEQ, ex_pc=0x100, ex_imm=0x40, redirect_ready=1 -> next cycle redirect_valid=1 and redirect_pc=0x140; FLUSH lasts 2 cycles; IDLE after 3 cycles.
REQ-032 JALR with rs1=0x2001, imm=0x4, redirect_ready low for 3 cycles -> redirect_pc=0x2004 held stable, ex_stall=1 for 3 cycles, then handshake.
REQ-033 JAL with pc=0x200, imm=0x6 -> target 0x206: misalign_exc pulses 1 cycle, misalign_addr=0x206, no redirect_valid.
REQ-034 Not-taken BNE, then a taken branch arriving during FLUSH -> no output for either; IDLE resumes cleanly.
REQ-035 rst_n pulled low while in REDIRECT -> all outputs 0 immediately; after release a JAL pc=0x0, imm=0x10 redirects to 0x10.
REQ-036 With PC_REDIRECT_STATS_EN, 5 taken branches and 3 not-taken -> stat_branches=8, stat_redirects=5.
